// File: rtl/hack_pkg.sv
// ============================================================================
// Module   : hack_pkg
// Brief    : Shared widths, instruction field indices and jump codes for the
//            Hack CPU core.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hack_pkg;

  localparam int WIDTH = 16;

  localparam int INSTR_TYPE = 15;
  localparam int A_BIT      = 12;
  localparam int COMP_HI    = 11;
  localparam int COMP_LO    = 6;
  localparam int DEST_HI    = 5;
  localparam int DEST_LO    = 3;
  localparam int JUMP_HI    = 2;
  localparam int JUMP_LO    = 0;

  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  function automatic logic jump_taken(input logic [2:0] j, input logic zr,
                                      input logic ng);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hack_cpu_if.sv
// ============================================================================
// Module   : hack_cpu_if
// Brief    : Instruction-ROM / data-RAM / debug bus of the Hack CPU core.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hack_cpu_if;
  import hack_pkg::*;

  logic [WIDTH-1:0] inM;
  logic [WIDTH-1:0] instruction;
  logic [WIDTH-1:0] outM;
  logic             writeM;
  logic [WIDTH-1:0] addressM;
  logic [WIDTH-1:0] pcaddr;
  logic [WIDTH-1:0] D_reg_out;
  logic [WIDTH-1:0] A_reg_out;

  // CPU side
  modport master (
    input  inM, instruction,
    output outM, writeM, addressM, pcaddr, D_reg_out, A_reg_out
  );

  // Memory / observer side
  modport slave (
    output inM, instruction,
    input  outM, writeM, addressM, pcaddr, D_reg_out, A_reg_out
  );

endinterface

`default_nettype wire

// File: rtl/hack_alu.sv
// ============================================================================
// Module   : hack_alu
// Brief    : Combinational Hack ALU with zero and negative flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hack_alu
  import hack_pkg::*;
(
  input  wire logic [WIDTH-1:0] i_x,
  input  wire logic [WIDTH-1:0] i_y,
  input  wire alu_ctrl_t        i_ctrl,
  output logic      [WIDTH-1:0] o_out,
  output logic                  o_zr,
  output logic                  o_ng
);

  logic [WIDTH-1:0] w_x0;
  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_y0;
  logic [WIDTH-1:0] w_y1;
  logic [WIDTH-1:0] w_f;

  always_comb begin
    w_x0  = i_ctrl.zx ? '0 : i_x;
    w_x1  = i_ctrl.nx ? ~w_x0 : w_x0;
    w_y0  = i_ctrl.zy ? '0 : i_y;
    w_y1  = i_ctrl.ny ? ~w_y0 : w_y0;
    w_f   = i_ctrl.f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    o_out = i_ctrl.no ? ~w_f : w_f;
    o_zr  = (o_out == '0);
    o_ng  = o_out[WIDTH-1];
  end

endmodule

`default_nettype wire

// File: rtl/hack_cpu.sv
// ============================================================================
// Module   : hack_cpu
// Brief    : Single-cycle 16-bit Hack CPU: A/D/PC registers, decode and jump.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hack_cpu
  import hack_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,
  hack_cpu_if.master bus
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_pc;

  logic             w_is_c;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_alu_out;
  logic             w_zr;
  logic             w_ng;
  logic [2:0]       w_dest;
  logic             w_jump;
  logic             w_unused_bits;

  assign w_is_c        = bus.instruction[INSTR_TYPE];
  assign w_y           = bus.instruction[A_BIT] ? bus.inM : r_a;
  assign w_unused_bits = ^bus.instruction[14:13];

  hack_alu u_alu (
    .i_x    (r_d),
    .i_y    (w_y),
    .i_ctrl (alu_ctrl_t'(bus.instruction[COMP_HI:COMP_LO])),
    .o_out  (w_alu_out),
    .o_zr   (w_zr),
    .o_ng   (w_ng)
  );

  // An A-instruction's low bits alias the dest/jump fields, so gate them off.
  assign w_dest = w_is_c ? bus.instruction[DEST_HI:DEST_LO] : 3'b000;
  assign w_jump = w_is_c & jump_taken(bus.instruction[JUMP_HI:JUMP_LO], w_zr, w_ng);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a  <= '0;
      r_d  <= '0;
      r_pc <= '0;
    end else begin
      if (!w_is_c) begin
        r_a <= bus.instruction;
      end else if (w_dest[2]) begin
        r_a <= w_alu_out;
      end
      if (w_dest[1]) begin
        r_d <= w_alu_out;
      end
      r_pc <= w_jump ? r_a : (r_pc + 1'b1);
    end
  end

  assign bus.outM      = w_alu_out;
  assign bus.writeM    = reset & w_dest[0];
  assign bus.addressM  = r_a;
  assign bus.pcaddr    = r_pc;
  assign bus.A_reg_out = r_a;
  assign bus.D_reg_out = r_d;

endmodule

`default_nettype wire

// File: tb/tb_hack_cpu.sv
// ============================================================================
// Module   : tb_hack_cpu
// Brief    : Scoreboard bench for hack_cpu driven by a hand-checked program.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hack_cpu;
  import hack_pkg::*;

  localparam int K_PC   = 0;
  localparam int K_A    = 1;
  localparam int K_D    = 2;
  localparam int K_WR   = 3;
  localparam int K_OUT  = 4;
  localparam int K_ADDR = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   drv_cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];
  exp_t mon_item;
  logic [15:0] mon_act;

  hack_cpu_if bus ();

  hack_cpu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sample(input int kind);
    case (kind)
      K_PC:    return bus.pcaddr;
      K_A:     return bus.A_reg_out;
      K_D:     return bus.D_reg_out;
      K_WR:    return {15'd0, bus.writeM};
      K_OUT:   return bus.outM;
      default: return bus.addressM;
    endcase
  endfunction

  // Pops every expectation due in this cycle and compares at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_item = sb_q.pop_front();
      mon_act  = sample(mon_item.kind);
      n_tests++;
      if (mon_item.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d",
                 mon_item.name, mon_item.cyc, cyc);
      end else if (mon_act !== mon_item.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)",
                 mon_item.name, mon_act, mon_item.exp, cyc);
      end
    end
  end

  task automatic step(input logic [15:0] instr, input logic [15:0] m,
                      input logic rst_n);
    @(posedge clk);
    #2;
    bus.instruction = instr;
    bus.inM         = m;
    reset           = rst_n;
    drv_cyc         = cyc;
  endtask

  task automatic now_chk(input int kind, input logic [15:0] v, input string n);
    exp_t e;
    e.cyc = drv_cyc; e.kind = kind; e.exp = v; e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic reg_chk(input int kind, input logic [15:0] v, input string n);
    exp_t e;
    e.cyc = drv_cyc + 1; e.kind = kind; e.exp = v; e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic regs(input logic [15:0] pc, input logic [15:0] a,
                      input logic [15:0] d, input string n);
    reg_chk(K_PC, pc, {n, ".pc"});
    reg_chk(K_A,  a,  {n, ".a"});
    reg_chk(K_D,  d,  {n, ".d"});
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    drv_cyc         = 0;
    reset           = 1'b0;
    bus.instruction = 16'h0000;
    bus.inM         = 16'h0000;

    // Reset under an all-ones instruction: writes and jump suppressed
    step(16'hFFFF, 16'h1234, 1'b0);
    now_chk(K_WR, 16'd0, "rst_wr");
    regs(16'd0, 16'd0, 16'd0, "rst");
    reg_chk(K_ADDR, 16'd0, "rst.addr");

    step(16'h3039, 16'd0, 1'b1);                 // @12345
    now_chk(K_WR, 16'd0, "aload_wr");
    regs(16'd1, 16'd12345, 16'd0, "aload");
    reg_chk(K_ADDR, 16'd12345, "aload.addr");

    step(16'hEC10, 16'd0, 1'b1);                 // D=A
    now_chk(K_OUT, 16'd12345, "dA_out");
    now_chk(K_WR, 16'd0, "dA_wr");
    regs(16'd2, 16'd12345, 16'd12345, "dA");

    step(16'h5BA0, 16'd0, 1'b1);                 // @23456
    regs(16'd3, 16'd23456, 16'd12345, "a2");

    step(16'hE1F0, 16'd0, 1'b1);                 // AD=A-D
    now_chk(K_OUT, 16'd11111, "amd_out");
    regs(16'd4, 16'd11111, 16'd11111, "amd");

    step(16'h03E8, 16'd0, 1'b1);                 // @1000
    regs(16'd5, 16'd1000, 16'd11111, "a1000");

    step(16'hE308, 16'd0, 1'b1);                 // M=D
    now_chk(K_WR, 16'd1, "mw_wr");
    now_chk(K_ADDR, 16'd1000, "mw_addr");
    now_chk(K_OUT, 16'd11111, "mw_out");
    regs(16'd6, 16'd1000, 16'd11111, "mw");

    step(16'hFDD0, 16'd11111, 1'b1);             // D=M+1
    now_chk(K_OUT, 16'd11112, "mp1_out");
    regs(16'd7, 16'd1000, 16'd11112, "mp1");

    step(16'hF4D0, 16'd11111, 1'b1);             // D=D-M
    regs(16'd8, 16'd1000, 16'd1, "dmm");

    step(16'h2B67, 16'd0, 1'b1);                 // @11111
    step(16'hEC10, 16'd0, 1'b1);                 // D=A
    regs(16'd10, 16'd11111, 16'd11111, "ld11111");
    step(16'h000E, 16'd0, 1'b1);                 // @14
    regs(16'd11, 16'd14, 16'd11111, "a14");

    step(16'hE304, 16'd0, 1'b1);                 // D;JLT (not taken)
    reg_chk(K_PC, 16'd12, "jlt.pc");
    step(16'hE301, 16'd0, 1'b1);                 // D;JGT (taken)
    reg_chk(K_PC, 16'd14, "jgt.pc");

    step(16'hEA90, 16'd0, 1'b1);                 // D=0
    now_chk(K_OUT, 16'd0, "dz_out");
    regs(16'd15, 16'd14, 16'd0, "dz");
    step(16'hE302, 16'd0, 1'b1);                 // D;JEQ (taken)
    reg_chk(K_PC, 16'd14, "jeq.pc");

    step(16'hEE90, 16'd0, 1'b1);                 // D=-1
    regs(16'd15, 16'd14, 16'hFFFF, "dm1");
    step(16'hE303, 16'd0, 1'b1);                 // D;JGE (not taken)
    reg_chk(K_PC, 16'd16, "jge.pc");
    step(16'hEA87, 16'd0, 1'b1);                 // 0;JMP
    now_chk(K_WR, 16'd0, "jmp_wr");
    reg_chk(K_PC, 16'd14, "jmp.pc");

    step(16'hEDE7, 16'd0, 1'b1);                 // A=A+1;JMP jumps to old A
    now_chk(K_OUT, 16'd15, "ajmp_out");
    regs(16'd14, 16'd15, 16'hFFFF, "ajmp");

    step(16'hE328, 16'd0, 1'b1);                 // AM=D writes at old A
    now_chk(K_WR, 16'd1, "am_wr");
    now_chk(K_ADDR, 16'd15, "am_addr");
    now_chk(K_OUT, 16'hFFFF, "am_out");
    regs(16'd15, 16'hFFFF, 16'hFFFF, "am");

    step(16'hEA87, 16'd0, 1'b1);                 // 0;JMP to 0xFFFF
    reg_chk(K_PC, 16'hFFFF, "jffff.pc");
    step(16'h0000, 16'd0, 1'b1);                 // @0, PC wraps
    regs(16'd0, 16'd0, 16'hFFFF, "wrap");

    step(16'hE7D0, 16'd0, 1'b1);                 // D=D+1 wraps to 0
    now_chk(K_OUT, 16'd0, "dwrap_out");
    regs(16'd1, 16'd0, 16'd0, "dwrap");

    step(16'h0028, 16'd0, 1'b1);                 // @40
    step(16'hEC10, 16'd0, 1'b1);                 // D=A
    step(16'hEA87, 16'd0, 1'b1);                 // 0;JMP
    regs(16'd40, 16'd40, 16'd40, "pc40");

    step(16'hFFFF, 16'd5, 1'b0);                 // reset under AMD=1;JMP
    now_chk(K_WR, 16'd0, "mrst1_wr");
    regs(16'd0, 16'd0, 16'd0, "mrst1");
    step(16'hFFFF, 16'd5, 1'b0);
    now_chk(K_WR, 16'd0, "mrst2_wr");
    regs(16'd0, 16'd0, 16'd0, "mrst2");

    step(16'h7FFF, 16'd0, 1'b1);                 // @32767
    now_chk(K_WR, 16'd0, "a32767_wr");
    regs(16'd1, 16'd32767, 16'd0, "a32767");
    reg_chk(K_ADDR, 16'd32767, "a32767.addr");

    step(16'h0000, 16'd0, 1'b1);
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
